// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display: nibble width,
// blank code and the active-low segment patterns (bit0 = CA ... bit6 = CG).
package seg_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_display_mux_if.sv
// Data/control/display bundle between a digit source and seg_display_mux.
interface seg_display_mux_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    hex_en;
  logic                    lzb_en;
  logic [2:0]              brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output value, dp_in, load, hex_en, lzb_en, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  value, dp_in, load, hex_en, lzb_en, brightness,
    output seg, dp, an, frame_start
  );

endinterface

// File: rtl/seg_hex_decoder.sv
// Nibble to active-low segment decoder; 10..15 shown only when hex_en is set.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                hex_en,
  output logic [6:0]          seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (hex_en || (nibble < 4'd10)) seg = SEG_PATTERNS[nibble];
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver: digit scan, frame-synchronised data
// loading, leading-zero blanking and PWM brightness on the anodes.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_display_mux_if.slave   bus
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = NIBBLE_W * NUM_DIGITS;
  localparam int STEP   = REFRESH_DIV / 8;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_last;
  logic                  frame_wrap;

  logic [VAL_W-1:0]      shadow_value;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [VAL_W-1:0]      active_value;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  pending;

  logic [NIBBLE_W-1:0]   cur_nibble;
  logic                  cur_dp;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  upper_zero;
  logic                  anode_on;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_last && (idx == IDX_LAST);

  // Scan: slot counter inside a digit, digit index across the frame.
  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt        <= '0;
      idx             <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= frame_wrap;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Loads land in the shadow and move to the active copy only at the frame
  // boundary; a load on the boundary cycle itself goes straight to active.
  // NOTE: shadow/active registers are reset too, so a load pending at reset is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      pending      <= 1'b0;
    end else if (frame_wrap) begin
      pending <= 1'b0;
      if (bus.load) begin
        active_value <= bus.value;
        active_dp    <= bus.dp_in;
      end else if (pending) begin
        active_value <= shadow_value;
        active_dp    <= shadow_dp;
      end
    end else if (bus.load) begin
      shadow_value <= bus.value;
      shadow_dp    <= bus.dp_in;
      pending      <= 1'b1;
    end
  end

  assign cur_nibble = active_value[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign cur_dp     = active_dp[idx];

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .hex_en (bus.hex_en),
    .seg    (dec_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero.
  // NOTE: every combinational output gets a default first so no latch is inferred;
  // upper_zero is a blocking running value that carries down the loop.
  always_comb begin
    lzb_mask   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero  = upper_zero && (active_value[k*NIBBLE_W +: NIBBLE_W] == '0);
      lzb_mask[k] = upper_zero;
    end
  end

  assign anode_on = int'(slot_cnt) < (int'(bus.brightness) + 1) * STEP;

  always_comb begin
    an_next  = '1;
    seg_next = dec_seg;
    if (anode_on) an_next = ~(NUM_DIGITS'(1) << idx);
    if (bus.lzb_en && lzb_mask[idx]) seg_next = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= '1;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_next;
      bus.seg <= seg_next;
      bus.dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux (4 digits, 8-cycle slots); each sample
// is taken on the falling edge and compared against hand-computed patterns.
module tb_seg_display_mux;

  localparam int ND = 4;
  localparam int RD = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  seg_display_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_display_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks one full frame starting from a frame_start sample; packs
  // {frame_start, an, seg, dp} into one comparison per cycle.
  task automatic check_frame(input string tag,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dpm, input int on_len);
    logic [6:0]  segs [4];
    logic [3:0]  exp_an;
    logic [12:0] exp_v;
    logic [12:0] obs_v;
    int d;
    int s;
    segs = '{s0, s1, s2, s3};
    for (int k = 0; k < ND * RD; k++) begin
      @(negedge clk);
      d      = k / RD;
      s      = k % RD;
      exp_an = (s < on_len) ? ~(4'b0001 << d) : 4'hF;
      exp_v  = {(k == ND * RD - 1), exp_an, segs[d], ~dpm[d]};
      obs_v  = {bus.frame_start, bus.an, bus.seg, bus.dp};
      check($sformatf("%s[%0d]", tag, k), 32'(obs_v), 32'(exp_v));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.value      = '0;
    bus.dp_in      = '0;
    bus.load       = 1'b0;
    bus.hex_en     = 1'b0;
    bus.lzb_en     = 1'b0;
    bus.brightness = 3'd7;
    step(3);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_frame_start", 32'(bus.frame_start), 32'h0);

    // Release reset and load 1234 on the first cycle; it shows after the first boundary.
    rst_n     = 1'b1;
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      cnt++;
      if (bus.frame_start) break;
    end
    check("first_frame_latency", 32'(cnt), 32'(ND * RD));
    check_frame("digits_1234", 7'h79, 7'h24, 7'h30, 7'h19, 4'b0000, 8);

    // Two loads mid-frame: current frame untouched, the later one wins.
    step(10);
    bus.value = 16'h1111; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(1);
    check("midframe_digit1", 32'(bus.seg), 32'h30);
    step(3);
    bus.value = 16'h2222; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(4);
    check("midframe_digit2", 32'(bus.seg), 32'h24);
    step(12);
    check("boundary_2222", 32'(bus.frame_start), 32'h1);
    check_frame("digits_2222", 7'h24, 7'h24, 7'h24, 7'h24, 4'b0000, 8);

    // Pending 9999 overridden by a load on the boundary cycle; pending ends cleared.
    step(5);
    bus.value = 16'h9999; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(25);
    bus.value = 16'h5678; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("boundary_5678", 32'(bus.frame_start), 32'h1);
    check_frame("bypass_5678_a", 7'h12, 7'h02, 7'h78, 7'h00, 4'b0000, 8);
    check_frame("bypass_5678_b", 7'h12, 7'h02, 7'h78, 7'h00, 4'b0000, 8);

    // 00A5 with blanking, decimal then hex, then blanking off.
    bus.value = 16'h00A5; bus.load = 1'b1; bus.lzb_en = 1'b1; bus.hex_en = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(ND * RD - 1);
    check_frame("lzb_dec_00A5", 7'h7F, 7'h7F, 7'h7F, 7'h12, 4'b0000, 8);
    bus.hex_en = 1'b1;
    check_frame("lzb_hex_00A5", 7'h7F, 7'h7F, 7'h08, 7'h12, 4'b0000, 8);
    bus.lzb_en = 1'b0;
    check_frame("nolzb_hex_00A5", 7'h40, 7'h40, 7'h08, 7'h12, 4'b0000, 8);

    // All-zero value: only digit 0 lit; dp on digit 2 only.
    bus.value = 16'h0000; bus.dp_in = 4'b0100; bus.load = 1'b1; bus.lzb_en = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(ND * RD - 1);
    check_frame("zero_dp2", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b0100, 8);
    bus.brightness = 3'd1;
    check_frame("bright1", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b0100, 2);

    // Reset mid-slot with a load pending: outputs clear at once, load is lost.
    bus.dp_in = 4'b0000;
    bus.value = 16'hFFFF;
    step(3);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(bus.an), 32'hF);
    check("midrst_seg", 32'(bus.seg), 32'h7F);
    check("midrst_dp", 32'(bus.dp), 32'h1);
    check("midrst_frame_start", 32'(bus.frame_start), 32'h0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.brightness = 3'd7;
    bus.lzb_en     = 1'b0;
    bus.hex_en     = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.frame_start) break;
    end
    check("rerelease_latency", 32'(cnt), 32'(ND * RD));
    check_frame("after_reset_zeros", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; SHALL be a multiple of 8 and at least 8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 value  input  4*NUM_DIGITS  digit nibbles; nibble k drives digit k; digit 0 is rightmost, an[0].
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-007 load  input  1  single-cycle strobe that captures value and dp_in.
REQ-008 hex_en  input  1  1 = nibbles 10..15 shown as A,b,C,d,E,F; 0 = decimal only.
REQ-009 lzb_en  input  1  leading-zero blanking enable.
REQ-010 brightness  input  3  anode duty in eighths: (brightness+1)/8.
REQ-011 seg  output  7  segments CA..CG, bit0 = CA, active-low.
REQ-012 dp  output  1  decimal point segment, active-low.
REQ-013 an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low or all high.
REQ-014 frame_start  output  1  one-cycle pulse when the scan returns to digit 0.

Function
REQ-015 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; at the terminal count the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 The cycle on which the index wraps to 0 SHALL be the frame boundary; frame_start SHALL be high for exactly that cycle.
REQ-017 load SHALL copy value/dp_in into a shadow register and set a pending flag; the last load before a boundary wins.
REQ-018 At a frame boundary with pending set, shadow SHALL be copied to the active register and pending cleared; displayed data SHALL never change mid-frame.
REQ-019 load coincident with a boundary SHALL bypass the shadow: the new value becomes active at that boundary and pending ends cleared.
REQ-020 Decoding: 0-9 standard patterns; 10-15 with hex_en=1 as A,b,C,d,E,F; 10-15 with hex_en=0 SHALL be blank (7'h7F).
REQ-021 With lzb_en=1, every zero nibble above the most significant nonzero nibble SHALL be blanked; digit 0 SHALL never be blanked by LZB; dp SHALL still follow the active dp bit.
REQ-022 Anode of the current digit SHALL be low only while slot_count < (brightness+1)*(REFRESH_DIV/8); otherwise all anodes high.
REQ-023 seg, dp, an SHALL be registered, one cycle after the slot counter/index values that produce them; never two anodes low.
REQ-024 Changes to hex_en, lzb_en and brightness SHALL take effect at the next cycle (not frame-synchronised).

Reset
REQ-025 During and after reset: an all ones, seg 7'h7F, dp 1, frame_start 0, slot counter 0, index 0, shadow/active/pending 0.
REQ-026 Reset asserted mid-frame SHALL drive all outputs to reset values immediately and discard any pending load.
REQ-027 The first frame_start after reset release SHALL occur NUM_DIGITS*REFRESH_DIV cycles later.

Structure
REQ-028 Package seg_pkg SHALL hold the 16 segment patterns, SEG_BLANK = 7'h7F and the digit-nibble width constant.
REQ-029 One combinational sub-module seg_hex_decoder (nibble, hex_en -> seg) SHALL implement REQ-020; scan, load, LZB and PWM logic stay in seg_display_mux.

Verification (NUM_DIGITS=4, REFRESH_DIV=8)
REQ-030 Reset then load value=16'h1234, brightness=7 -> after next boundary an cycles 1110,1101,1011,0111 for 8 cycles each; seg = 2,3,... wait order 4,3,2,1 patterns 7'h19,7'h30,7'h24,7'h79.
REQ-031 value=16'h00A5, hex_en=0, lzb_en=1 -> digits 3,2 blank, digit 1 blank (A in decimal), digit 0 = 7'h12; with hex_en=1 digit 1 = A pattern 7'h08.
REQ-032 value=16'h0000, lzb_en=1 -> only digit 0 shows 7'h40; dp_in=4'b0100 -> dp low only during digit 2 slot.
REQ-033 load 16'h1111 mid-frame, then 16'h2222 before boundary -> current frame unchanged, next frame shows 2222 only; load on boundary cycle -> applied that frame.
REQ-034 brightness=1 -> each anode low for 2 of 8 cycles; assert rst_n=0 mid-slot -> an=4'hF, seg=7'h7F next sample, pending load lost.
